axil_memtest: RTL

AXIL_MEMTEST -- requirements
Module: axil_memtest

---
 rtl/sdram_pkg.sv | 29 ++
 rtl/lfsr32.sv | 36 +++
 rtl/axil_memtest.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the AXI-Lite memory tester:
//   state_t    - tester FSM states
//   LFSR_POLY  - Galois feedback mask for x^32 + x^22 + x^2 + x + 1
//   RESP_OKAY  - AXI OKAY response code
//   lfsr_step  - one right-shifting Galois LFSR step
// ---------------------------------------------------------------------------
package sdram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_RESP,
        FINISH
    } state_t;

    // Bit (k-1) set for each x^k term of the polynomial (constant term implicit).
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

endpackage

// File: rtl/lfsr32.sv
// ---------------------------------------------------------------------------
// lfsr32
// 32-bit Galois LFSR producing the test data pattern.
// Ports:
//   clk     - clock
//   rst_n   - synchronous active-low reset (value returns to SEED)
//   load    - reload SEED
//   advance - step to the next state (ignored when load is high)
//   value   - current LFSR state
// ---------------------------------------------------------------------------
module lfsr32 #(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] value
);
    import sdram_pkg::*;

    logic [31:0] r_value;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value <= SEED;
        end else if (load) begin
            r_value <= SEED;
        end else if (advance) begin
            r_value <= lfsr_step(r_value);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/axil_memtest.sv
// ---------------------------------------------------------------------------
// axil_memtest
// Writes NUM_WORDS LFSR words over AXI-Lite starting at BASE_ADDR, reads them
// back and counts mismatches and non-OKAY responses. One transaction at a time.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   start                 - one-cycle pulse, starts a run when idle
//   m_axil_aw*/w*/b*      - AXI-Lite write manager channels
//   m_axil_ar*/r*         - AXI-Lite read manager channels
//   busy                  - run in progress
//   done                  - one-cycle pulse at end of run
//   pass                  - last run had no errors (held until next start)
//   err_count             - saturating error count
//   first_err_addr        - address of the first error in the run, else 0
// ---------------------------------------------------------------------------
module axil_memtest #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_WORDS = 1024,
    parameter logic [31:0] SEED      = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] m_axil_awaddr,
    output logic        m_axil_awvalid,
    input  logic        m_axil_awready,
    output logic [31:0] m_axil_wdata,
    output logic [3:0]  m_axil_wstrb,
    output logic        m_axil_wvalid,
    input  logic        m_axil_wready,
    input  logic [1:0]  m_axil_bresp,
    input  logic        m_axil_bvalid,
    output logic        m_axil_bready,
    output logic [31:0] m_axil_araddr,
    output logic        m_axil_arvalid,
    input  logic        m_axil_arready,
    input  logic [31:0] m_axil_rdata,
    input  logic [1:0]  m_axil_rresp,
    input  logic        m_axil_rvalid,
    output logic        m_axil_rready,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] first_err_addr
);
    import sdram_pkg::*;

    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

    state_t      r_state;
    logic [15:0] r_index;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [15:0] r_err_count;
    logic [31:0] r_first_err_addr;

    logic [31:0] w_addr;
    logic [31:0] w_lfsr_value;
    logic        w_last;
    logic        w_b_fire;
    logic        w_r_fire;
    logic        w_aw_ok;
    logic        w_w_ok;
    logic        w_err_event;
    logic [15:0] w_err_next;
    logic        w_lfsr_load;
    logic        w_lfsr_advance;

    // Address only changes when index changes, which never happens while a
    // valid is raised, so awaddr/araddr are stable for the whole handshake.
    assign w_addr   = BASE_ADDR + {14'd0, r_index, 2'b00};
    assign w_last   = (r_index == LAST_IDX);
    assign w_b_fire = (r_state == WR_RESP) && r_bready && m_axil_bvalid;
    assign w_r_fire = (r_state == RD_RESP) && r_rready && m_axil_rvalid;

    // A channel counts as accepted once its valid is down, or its ready is up now.
    assign w_aw_ok = !r_awvalid || m_axil_awready;
    assign w_w_ok  = !r_wvalid  || m_axil_wready;

    // A data mismatch and a bad rresp on the same beat are one error.
    assign w_err_event = (w_b_fire && (m_axil_bresp != RESP_OKAY)) ||
                         (w_r_fire && ((m_axil_rdata != w_lfsr_value) ||
                                       (m_axil_rresp != RESP_OKAY)));
    assign w_err_next  = r_err_count +
                         {15'd0, (w_err_event && (r_err_count != 16'hFFFF))};

    assign w_lfsr_load    = ((r_state == IDLE) && start) || (w_b_fire && w_last);
    assign w_lfsr_advance = (w_b_fire || w_r_fire) && !w_last;

    lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_lfsr_load),
        .advance (w_lfsr_advance),
        .value   (w_lfsr_value)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_index          <= 16'd0;
            r_awvalid        <= 1'b0;
            r_wvalid         <= 1'b0;
            r_bready         <= 1'b0;
            r_arvalid        <= 1'b0;
            r_rready         <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= 16'd0;
            r_first_err_addr <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state          <= WR_ADDR;
                        r_index          <= 16'd0;
                        r_err_count      <= 16'd0;
                        r_first_err_addr <= 32'd0;
                        r_pass           <= 1'b0;
                        r_busy           <= 1'b1;
                        r_awvalid        <= 1'b1;
                        r_wvalid         <= 1'b1;
                    end
                end
                WR_ADDR: begin
                    if (r_awvalid && m_axil_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && m_axil_wready)   r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_state  <= WR_RESP;
                        r_bready <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (w_b_fire) begin
                        r_bready <= 1'b0;
                        if (w_last) begin
                            r_state   <= RD_ADDR;
                            r_index   <= 16'd0;
                            r_arvalid <= 1'b1;
                        end else begin
                            r_state   <= WR_ADDR;
                            r_index   <= r_index + 16'd1;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_axil_arready) begin
                        r_state   <= RD_RESP;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (w_r_fire) begin
                        r_rready <= 1'b0;
                        if (w_last) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 16'd0);
                        end else begin
                            r_state   <= RD_ADDR;
                            r_index   <= r_index + 16'd1;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase

            if (w_err_event) begin
                r_err_count <= w_err_next;
                if (r_err_count == 16'd0) r_first_err_addr <= w_addr;
            end
        end
    end

    assign m_axil_awaddr  = w_addr;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = w_lfsr_value;
    assign m_axil_wstrb   = 4'hF;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_bready;
    assign m_axil_araddr  = w_addr;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;

endmodule
